// File: rtl/axi_burst_sequencer.sv
// axi_burst_sequencer
// Takes one AXI4 address-phase transfer (AR or AW) and steps through its
// len+1 beats. Each beat carries its address, the burst id and a last flag.
// Beat addresses follow the FIXED/INCR/WRAP rules. Only one burst is in
// flight at a time, so ax_ready stays low from acceptance until the last
// beat is consumed.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A valid output is never withdrawn, and its payload is never
// changed, until that transfer has taken place.
module axi_burst_sequencer #(
    parameter bit ALIGN_ADDR = 1'b1,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ax_valid,
    output logic                  ax_ready,
    input  logic [ID_WIDTH-1:0]   ax_id,
    input  logic [ADDR_WIDTH-1:0] ax_addr,
    input  logic [1:0]            ax_burst,
    input  logic [2:0]            ax_size,
    input  logic [7:0]            ax_len,
    output logic                  beat_valid,
    input  logic                  beat_ready,
    output logic [ADDR_WIDTH-1:0] beat_addr,
    output logic [ID_WIDTH-1:0]   beat_id,
    output logic                  beat_last,
    output logic                  beat_err,
    output logic                  dbg_state
);

    localparam int                  DATA_SIZE   = $clog2(DATA_WIDTH / 8);
    localparam logic [2:0]          DATA_SIZE_L = 3'(DATA_SIZE);
    localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;
    localparam logic [1:0] BURST_RSVD  = 2'd3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Burst context captured at acceptance and advanced on every beat.
    logic [ID_WIDTH-1:0]   id_q,    id_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [1:0]            burst_q, burst_d;
    logic [2:0]            size_q,  size_d;
    logic [7:0]            len_q,   len_d;
    logic [7:0]            count_q, count_d;
    logic                  last_q,  last_d;
    logic                  err_q,   err_d;

    logic                  ax_fire;
    logic                  beat_fire;
    logic [2:0]            size_clamped;

    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] sum;
    logic [ADDR_WIDTH-1:0] low_mask;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  wrap_ok;

    assign ax_fire      = ax_valid & ax_ready;
    assign beat_fire    = beat_valid & beat_ready;
    // A beat can never be wider than the data bus.
    assign size_clamped = (ax_size > DATA_SIZE_L) ? DATA_SIZE_L : ax_size;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: idle until a request is taken, busy until the last beat leaves.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (ax_fire) state_d = ST_BURST;
            ST_BURST: if (beat_fire && last_q) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from the registered state.
    always_comb begin
        ax_ready   = 1'b0;
        beat_valid = 1'b0;
        case (state_q)
            ST_IDLE:  ax_ready   = 1'b1;
            ST_BURST: beat_valid = 1'b1;
            default: begin
                ax_ready   = 1'b0;
                beat_valid = 1'b0;
            end
        endcase
    end

    // Address of the following beat, derived from the current one.
    always_comb begin
        step      = ONE << size_q;
        sum       = addr_q + step;
        low_mask  = step - ONE;
        wrap_mask = ADDR_WIDTH'(len_q[3:0]) << size_q;
        // Only 2, 4, 8 or 16 beat WRAP bursts are legal; others fall back to INCR.
        wrap_ok   = (len_q == 8'd1) || (len_q == 8'd3) ||
                    (len_q == 8'd7) || (len_q == 8'd15);
        incr_addr = ALIGN_ADDR ? (sum & ~low_mask) : sum;
        case (burst_q)
            BURST_INCR: next_addr = incr_addr;
            BURST_WRAP: next_addr = wrap_ok ? ((addr_q & ~wrap_mask) | (sum & wrap_mask))
                                            : incr_addr;
            BURST_FIXED: next_addr = addr_q;
            BURST_RSVD:  next_addr = addr_q;
            default:     next_addr = addr_q;
        endcase
    end

    // Context update: load on acceptance, advance on each consumed beat.
    always_comb begin
        id_d    = id_q;
        addr_d  = addr_q;
        burst_d = burst_q;
        size_d  = size_q;
        len_d   = len_q;
        count_d = count_q;
        last_d  = last_q;
        err_d   = err_q;
        if (ax_fire) begin
            id_d    = ax_id;
            addr_d  = ax_addr;
            burst_d = ax_burst;
            size_d  = size_clamped;
            len_d   = ax_len;
            count_d = 8'd0;
            last_d  = (ax_len == 8'd0);
            err_d   = (ax_burst == BURST_RSVD);
        end else if (beat_fire) begin
            if (last_q) begin
                // Burst done; flags drop so idle outputs look clean.
                count_d = 8'd0;
                last_d  = 1'b0;
                err_d   = 1'b0;
            end else begin
                count_d = count_q + 8'd1;
                addr_d  = next_addr;
                last_d  = ((count_q + 8'd1) == len_q);
            end
        end
    end

    // Context registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_q    <= '0;
            addr_q  <= '0;
            burst_q <= 2'd0;
            size_q  <= 3'd0;
            len_q   <= 8'd0;
            count_q <= 8'd0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            id_q    <= id_d;
            addr_q  <= addr_d;
            burst_q <= burst_d;
            size_q  <= size_d;
            len_q   <= len_d;
            count_q <= count_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign beat_addr = addr_q;
    assign beat_id   = id_q;
    assign beat_last = last_q;
    assign beat_err  = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_axi_burst_sequencer.sv
// Testbench for axi_burst_sequencer: two instances (ALIGN_ADDR=1 and 0)
// share the same stimulus. It runs a table of directed bursts, a few
// hand-written corner sequences and randomized bursts checked against an
// arithmetic address model.
`timescale 1ns/1ps
module tb_axi_burst_sequencer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       ax_valid;
    logic [3:0] ax_id;
    logic [11:0] ax_addr;
    logic [1:0] ax_burst;
    logic [2:0] ax_size;
    logic [7:0] ax_len;
    logic       beat_ready;

    logic        a_ax_ready, a_beat_valid, a_beat_last, a_beat_err, a_dbg;
    logic [11:0] a_beat_addr;
    logic [3:0]  a_beat_id;
    logic        b_ax_ready, b_beat_valid, b_beat_last, b_beat_err, b_dbg;
    logic [11:0] b_beat_addr;
    logic [3:0]  b_beat_id;

    axi_burst_sequencer #(.ALIGN_ADDR(1'b1), .ADDR_WIDTH(12), .DATA_WIDTH(32), .ID_WIDTH(4)) dut_a (
        .clk(clk), .rst(rst), .ax_valid(ax_valid), .ax_ready(a_ax_ready), .ax_id(ax_id),
        .ax_addr(ax_addr), .ax_burst(ax_burst), .ax_size(ax_size), .ax_len(ax_len),
        .beat_valid(a_beat_valid), .beat_ready(beat_ready), .beat_addr(a_beat_addr),
        .beat_id(a_beat_id), .beat_last(a_beat_last), .beat_err(a_beat_err), .dbg_state(a_dbg)
    );

    axi_burst_sequencer #(.ALIGN_ADDR(1'b0), .ADDR_WIDTH(12), .DATA_WIDTH(32), .ID_WIDTH(4)) dut_b (
        .clk(clk), .rst(rst), .ax_valid(ax_valid), .ax_ready(b_ax_ready), .ax_id(ax_id),
        .ax_addr(ax_addr), .ax_burst(ax_burst), .ax_size(ax_size), .ax_len(ax_len),
        .beat_valid(b_beat_valid), .beat_ready(beat_ready), .beat_addr(b_beat_addr),
        .beat_id(b_beat_id), .beat_last(b_beat_last), .beat_err(b_beat_err), .dbg_state(b_dbg)
    );

    // ---------------- scoreboard ----------------
    // Entry layout: {err, last, id[3:0], addr_align1[11:0], addr_align0[11:0]}
    logic [29:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [29:0] pack_exp(input logic err, input logic last, input logic [3:0] id,
                                             input logic [11:0] a1, input logic [11:0] a0);
        return {err, last, id, a1, a0};
    endfunction

    // Address of beat i from the AXI rules, using plain integer arithmetic.
    function automatic logic [11:0] model_addr(input logic [11:0] start, input logic [1:0] burst,
                                               input logic [2:0] size, input logic [7:0] len,
                                               input int i, input bit align);
        int s, bytes, total, bnd, a;
        s = int'(start);
        bytes = 1 << ((size > 3'd2) ? 2 : int'(size));
        if (burst == 2'd0 || burst == 2'd3) return start;
        if (burst == 2'd2 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
            total = bytes * (int'(len) + 1);
            bnd = (s / total) * total;
            return 12'(bnd + ((s - bnd + i * bytes) % total));
        end
        if (i == 0) return start;
        if (align) a = (s / bytes) * bytes + i * bytes;
        else       a = s + i * bytes;
        return 12'(a % 4096);
    endfunction

    task automatic push_model(input logic [3:0] id, input logic [11:0] addr, input logic [1:0] burst,
                              input logic [2:0] size, input logic [7:0] len);
        for (int i = 0; i <= int'(len); i++) begin
            exp_q.push_back(pack_exp(burst == 2'd3, i == int'(len), id,
                                     model_addr(addr, burst, size, len, i, 1'b1),
                                     model_addr(addr, burst, size, len, i, 1'b0)));
        end
    endtask

    // ---------------- driver ----------------
    // Called just after a rising edge with both DUTs idle. Presents the request,
    // then consumes beats against exp_q. Returns just after the edge that
    // consumed the last beat. stall_beat >= 0 holds beat_ready low for 3 cycles
    // when that beat is first offered.
    task automatic drive_burst(input logic [3:0] id, input logic [11:0] addr, input logic [1:0] burst,
                               input logic [2:0] size, input logic [7:0] len,
                               input int stall_beat, input int stall_pct);
        int wait_n;
        int cyc;
        int beat_idx;
        int stall_left;
        bit stall_done;
        logic [29:0] e;
        ax_valid = 1'b1; ax_id = id; ax_addr = addr; ax_burst = burst; ax_size = size; ax_len = len;
        beat_ready = 1'b0;
        wait_n = 0;
        @(negedge clk);
        while (!a_ax_ready && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        chk("accept_wait", 32'(wait_n), 32'd0);
        chk("accept_ready_b", 32'(b_ax_ready), 32'd1);
        @(posedge clk); #1;
        // Scramble the request bus; the DUT must use only what it latched.
        ax_valid = 1'b0; ax_id = 4'($urandom); ax_addr = 12'($urandom);
        ax_burst = 2'($urandom); ax_size = 3'($urandom); ax_len = 8'($urandom);
        beat_idx = 0; cyc = 0; stall_left = 0; stall_done = 1'b0;
        while (exp_q.size() > 0 && cyc < 3000) begin
            if (beat_idx == stall_beat && !stall_done) begin
                stall_left = 3;
                stall_done = 1'b1;
            end
            if (stall_left > 0) begin
                beat_ready = 1'b0;
                stall_left--;
            end else begin
                beat_ready = ($urandom_range(99) >= 32'(stall_pct));
            end
            @(negedge clk);
            e = exp_q[0];
            chk("beat_valid_a", 32'(a_beat_valid), 32'd1);
            chk("beat_valid_b", 32'(b_beat_valid), 32'd1);
            chk("ax_ready_busy", 32'(a_ax_ready), 32'd0);
            chk("beat_addr_align1", 32'(a_beat_addr), 32'(e[23:12]));
            chk("beat_addr_align0", 32'(b_beat_addr), 32'(e[11:0]));
            chk("beat_id_a", 32'(a_beat_id), 32'(e[27:24]));
            chk("beat_id_b", 32'(b_beat_id), 32'(e[27:24]));
            chk("beat_last_a", 32'(a_beat_last), 32'(e[28]));
            chk("beat_last_b", 32'(b_beat_last), 32'(e[28]));
            chk("beat_err_a", 32'(a_beat_err), 32'(e[29]));
            chk("beat_err_b", 32'(b_beat_err), 32'(e[29]));
            if (!a_beat_valid) break;
            if (beat_ready) begin
                void'(exp_q.pop_front());
                beat_idx++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("beats_outstanding", 32'(exp_q.size()), 32'd0);
        if (exp_q.size() > 0) begin
            exp_q.delete();
            @(posedge clk); #1;
        end
        beat_ready = 1'b0;
        chk("idle_ready_a", 32'(a_ax_ready), 32'd1);
        chk("idle_valid_a", 32'(a_beat_valid), 32'd0);
        chk("idle_ready_b", 32'(b_ax_ready), 32'd1);
        chk("idle_valid_b", 32'(b_beat_valid), 32'd0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [3:0]       id;
        logic [11:0]      addr;
        logic [1:0]       burst;
        logic [2:0]       size;
        logic [7:0]       len;
        int               stall_beat;
        logic [3:0][11:0] a1;
        logic [3:0][11:0] a0;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] id, input logic [11:0] addr, input logic [1:0] burst,
                                input logic [2:0] size, input logic [7:0] len, input int stall_beat,
                                input logic [11:0] p0, input logic [11:0] p1, input logic [11:0] p2,
                                input logic [11:0] p3, input logic [11:0] q0, input logic [11:0] q1,
                                input logic [11:0] q2, input logic [11:0] q3);
        vec_t v;
        v.id = id; v.addr = addr; v.burst = burst; v.size = size; v.len = len;
        v.stall_beat = stall_beat;
        v.a1[0] = p0; v.a1[1] = p1; v.a1[2] = p2; v.a1[3] = p3;
        v.a0[0] = q0; v.a0[1] = q1; v.a0[2] = q2; v.a0[3] = q3;
        return v;
    endfunction

    vec_t tab[14];

    // ---------------- watchdog ----------------
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        //            id     addr    bst   sz    len  stall  align1 beats 0..3            align0 beats 0..3
        tab[0]  = mk(4'h1, 12'h004, 2'd1, 3'd2, 8'd3, -1, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h004, 12'h008, 12'h00C, 12'h010);
        tab[1]  = mk(4'h2, 12'h013, 2'd1, 3'd2, 8'd2, -1, 12'h013, 12'h014, 12'h018, 12'h000, 12'h013, 12'h017, 12'h01B, 12'h000);
        tab[2]  = mk(4'h3, 12'h038, 2'd2, 3'd2, 8'd3, -1, 12'h038, 12'h03C, 12'h030, 12'h034, 12'h038, 12'h03C, 12'h030, 12'h034);
        tab[3]  = mk(4'h4, 12'h040, 2'd1, 3'd2, 8'd0, -1, 12'h040, 12'h000, 12'h000, 12'h000, 12'h040, 12'h000, 12'h000, 12'h000);
        tab[4]  = mk(4'h5, 12'h100, 2'd0, 3'd2, 8'd2,  1, 12'h100, 12'h100, 12'h100, 12'h000, 12'h100, 12'h100, 12'h100, 12'h000);
        tab[5]  = mk(4'h6, 12'h100, 2'd3, 3'd2, 8'd2,  1, 12'h100, 12'h100, 12'h100, 12'h000, 12'h100, 12'h100, 12'h100, 12'h000);
        tab[6]  = mk(4'h7, 12'hFFC, 2'd1, 3'd2, 8'd1, -1, 12'hFFC, 12'h000, 12'h000, 12'h000, 12'hFFC, 12'h000, 12'h000, 12'h000);
        tab[7]  = mk(4'h8, 12'h000, 2'd1, 3'd3, 8'd1, -1, 12'h000, 12'h004, 12'h000, 12'h000, 12'h000, 12'h004, 12'h000, 12'h000);
        tab[8]  = mk(4'h9, 12'h038, 2'd2, 3'd2, 8'd2, -1, 12'h038, 12'h03C, 12'h040, 12'h000, 12'h038, 12'h03C, 12'h040, 12'h000);
        tab[9]  = mk(4'hA, 12'h03A, 2'd2, 3'd2, 8'd3, -1, 12'h03A, 12'h03E, 12'h032, 12'h036, 12'h03A, 12'h03E, 12'h032, 12'h036);
        tab[10] = mk(4'hB, 12'h021, 2'd1, 3'd1, 8'd1, -1, 12'h021, 12'h022, 12'h000, 12'h000, 12'h021, 12'h023, 12'h000, 12'h000);
        tab[11] = mk(4'hC, 12'h005, 2'd2, 3'd0, 8'd1, -1, 12'h005, 12'h004, 12'h000, 12'h000, 12'h005, 12'h004, 12'h000, 12'h000);
        tab[12] = mk(4'hD, 12'h0FE, 2'd1, 3'd1, 8'd3,  0, 12'h0FE, 12'h100, 12'h102, 12'h104, 12'h0FE, 12'h100, 12'h102, 12'h104);
        tab[13] = mk(4'hE, 12'h3F4, 2'd2, 3'd7, 8'd1, -1, 12'h3F4, 12'h3F0, 12'h000, 12'h000, 12'h3F4, 12'h3F0, 12'h000, 12'h000);

        rst = 1'b1; ax_valid = 1'b0; ax_id = 4'd0; ax_addr = 12'd0; ax_burst = 2'd0;
        ax_size = 3'd0; ax_len = 8'd0; beat_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ax_ready", 32'(a_ax_ready), 32'd1);
        chk("rst_beat_valid", 32'(a_beat_valid), 32'd0);
        chk("rst_beat_last", 32'(a_beat_last), 32'd0);
        chk("rst_beat_err", 32'(a_beat_err), 32'd0);
        chk("rst_beat_addr", 32'(a_beat_addr), 32'd0);
        chk("rst_beat_id", 32'(a_beat_id), 32'd0);
        chk("rst_state", 32'(a_dbg), 32'd0);
        chk("rst_ax_ready_b", 32'(b_ax_ready), 32'd1);
        rst = 1'b0;

        // Directed table, run back to back (each accepted the cycle after the previous last).
        for (int t = 0; t < 14; t++) begin
            for (int i = 0; i <= int'(tab[t].len); i++) begin
                exp_q.push_back(pack_exp(tab[t].burst == 2'd3, i == int'(tab[t].len), tab[t].id,
                                         tab[t].a1[i], tab[t].a0[i]));
            end
            drive_burst(tab[t].id, tab[t].addr, tab[t].burst, tab[t].size, tab[t].len,
                        tab[t].stall_beat, 0);
        end

        // A request held during a burst is ignored until the sequencer is idle.
        ax_valid = 1'b1; ax_id = 4'h1; ax_addr = 12'h0AA; ax_burst = 2'd0; ax_size = 3'd2; ax_len = 8'd1;
        @(posedge clk); #1;
        ax_id = 4'h2; ax_addr = 12'h555; ax_burst = 2'd1; ax_len = 8'd0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("held_addr", 32'(a_beat_addr), 32'h0AA);
            chk("held_id", 32'(a_beat_id), 32'h1);
            chk("held_ax_ready", 32'(a_ax_ready), 32'd0);
        end
        @(posedge clk); #1;
        beat_ready = 1'b1;
        @(negedge clk);
        chk("held_beat0_last", 32'(a_beat_last), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("held_beat1_addr", 32'(a_beat_addr), 32'h0AA);
        chk("held_beat1_last", 32'(a_beat_last), 32'd1);
        @(posedge clk); #1;
        chk("held_then_ready", 32'(a_ax_ready), 32'd1);
        @(posedge clk); #1;
        ax_valid = 1'b0;
        @(negedge clk);
        chk("held_new_valid", 32'(a_beat_valid), 32'd1);
        chk("held_new_addr", 32'(a_beat_addr), 32'h555);
        chk("held_new_id", 32'(a_beat_id), 32'h2);
        chk("held_new_last", 32'(a_beat_last), 32'd1);
        @(posedge clk); #1;
        beat_ready = 1'b0;
        chk("held_new_done", 32'(a_ax_ready), 32'd1);

        // Reset on the second beat of an INCR len 7 burst abandons it.
        ax_valid = 1'b1; ax_id = 4'hF; ax_addr = 12'h200; ax_burst = 2'd1; ax_size = 3'd2; ax_len = 8'd7;
        @(posedge clk); #1;
        ax_valid = 1'b0;
        beat_ready = 1'b1;
        @(negedge clk);
        chk("rstmid_beat0", 32'(a_beat_addr), 32'h200);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstmid_beat1", 32'(a_beat_addr), 32'h204);
        chk("rstmid_beat1_valid", 32'(a_beat_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        beat_ready = 1'b0;
        chk("rstmid_valid_a", 32'(a_beat_valid), 32'd0);
        chk("rstmid_valid_b", 32'(b_beat_valid), 32'd0);
        chk("rstmid_ready_a", 32'(a_ax_ready), 32'd1);
        chk("rstmid_ready_b", 32'(b_ax_ready), 32'd1);
        push_model(4'h3, 12'h300, 2'd1, 3'd2, 8'd2);
        drive_burst(4'h3, 12'h300, 2'd1, 3'd2, 8'd2, -1, 0);

        // Randomized bursts against the address model.
        for (int r = 0; r < 40; r++) begin
            logic [3:0]  rid;
            logic [11:0] raddr;
            logic [1:0]  rburst;
            logic [2:0]  rsize;
            logic [7:0]  rlen;
            rid    = 4'($urandom);
            raddr  = 12'($urandom);
            rburst = 2'($urandom_range(3));
            rsize  = 3'($urandom_range(7));
            rlen   = (r % 10 == 9) ? 8'($urandom_range(255)) : 8'($urandom_range(15));
            if (r == 19) rlen = 8'd255;
            push_model(rid, raddr, rburst, rsize, rlen);
            drive_burst(rid, raddr, rburst, rsize, rlen, -1, 30);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
